lif_scheduler: RTL

Time-multiplexed leaky-integrate-and-fire engine that sequences one shared LIF update datapath across `N_NEURONS` virtual neurons. The engine keeps per-neuron membrane state, refractory counters and input currents. A `start` pulse runs one sweep of the update datapath over all neurons. Spikes are queued as neuron-index events in a small FIFO with a valid/ready output handshake. The block sits between the tile's IO wrapper (config and current writes) and downstream spike consumers.

---
 rtl/lif_scheduler_if.sv | 35 +++
 rtl/lif_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/lif_scheduler_if.sv
// Host-side bus of the LIF scheduler: sweep control, config/current writes,
// membrane readout and the spike event stream.
interface lif_scheduler_if #(
    parameter int IDX_W = 2
);
    logic             start;
    logic             busy;
    logic             done;
    logic             cfg_we;
    logic [1:0]       cfg_addr;
    logic [7:0]       cfg_data;
    logic             cur_we;
    logic [IDX_W-1:0] cur_idx;
    logic [7:0]       cur_data;
    logic [IDX_W-1:0] state_sel;
    logic [7:0]       state_out;
    logic             spk_valid;
    logic [IDX_W-1:0] spk_idx;
    logic             spk_ready;
    logic             overflow;

    // Host / IO wrapper side
    modport master (
        output start, cfg_we, cfg_addr, cfg_data, cur_we, cur_idx, cur_data,
               state_sel, spk_ready,
        input  busy, done, state_out, spk_valid, spk_idx, overflow
    );

    // Scheduler side
    modport slave (
        input  start, cfg_we, cfg_addr, cfg_data, cur_we, cur_idx, cur_data,
               state_sel, spk_ready,
        output busy, done, state_out, spk_valid, spk_idx, overflow
    );
endinterface

// File: rtl/lif_scheduler.sv
// Time-multiplexed leaky-integrate-and-fire engine. One update datapath is
// walked across N_NEURONS virtual neurons per sweep; spikes are queued as
// neuron indices in a small FIFO with a valid/ready drain port.
module lif_scheduler #(
    parameter int N_NEURONS  = 4,
    parameter int IDX_W      = 2,
    parameter int FIFO_DEPTH = 4   // power of two, >= 2
) (
    input  logic             clk,
    input  logic             rst_n,
    lif_scheduler_if.slave   bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_SWEEP} state_e;

    state_e                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic                            done_q;

    // Per-neuron state
    logic [N_NEURONS-1:0][7:0]       v_q;
    logic [N_NEURONS-1:0][3:0]       cnt_q;
    logic [N_NEURONS-1:0][7:0]       cur_q;

    // Configuration
    logic [7:0]                      thr_q;
    logic [2:0]                      leak_q;
    logic [3:0]                      refrac_q;
    logic [N_NEURONS-1:0]            mask_q;
    logic [N_NEURONS-1:0]            mask_wr;

    // Spike FIFO
    logic [FIFO_DEPTH-1:0][IDX_W-1:0] mem_q;
    logic [PTR_W-1:0]                wr_q, rd_q;
    logic [PTR_W:0]                  count_q;
    logic                            overflow_q;
    logic [7:0]                      state_out_q;

    // Datapath signals
    logic                            upd_en, last_upd;
    logic [7:0]                      v_cur, c_cur, v_new, sat;
    logic [3:0]                      cnt_cur, cnt_new;
    logic [8:0]                      leaked, sum9;
    logic                            spike;
    logic                            fifo_full, pop, push, drop;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // FSM next state: start is only looked at in IDLE, so pulses while busy are lost
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_SWEEP;
                    idx_d   = '0;
                end
            end
            S_SWEEP: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(N_NEURONS - 1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: one neuron is updated on every SWEEP edge
    always_comb begin
        upd_en   = (state_q == S_SWEEP);
        last_upd = upd_en && (idx_q == IDX_W'(N_NEURONS - 1));
        bus.busy = upd_en;
    end

    // LIF update for the neuron currently addressed by idx_q
    always_comb begin
        v_cur   = v_q[idx_q];
        cnt_cur = cnt_q[idx_q];
        c_cur   = cur_q[idx_q];
        leaked  = {1'b0, v_cur} - {1'b0, (v_cur >> leak_q)};
        sum9    = leaked + {1'b0, c_cur};
        sat     = sum9[8] ? 8'hFF : sum9[7:0];
        v_new   = v_cur;
        cnt_new = cnt_cur;
        spike   = 1'b0;
        if (upd_en && mask_q[idx_q]) begin
            if (cnt_cur != 4'd0) begin
                v_new   = 8'd0;
                cnt_new = cnt_cur - 4'd1;
            end else if (sat >= thr_q) begin
                spike   = 1'b1;
                v_new   = 8'd0;
                cnt_new = refrac_q;
            end else begin
                v_new   = sat;
            end
        end
    end

    // Membrane and refractory state; currents are independent host writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            cnt_q <= '0;
            cur_q <= '0;
        end else begin
            if (upd_en) begin
                v_q[idx_q]   <= v_new;
                cnt_q[idx_q] <= cnt_new;
            end
            if (bus.cur_we) cur_q[bus.cur_idx] <= bus.cur_data;
        end
    end

    // Mask write data: zero-extend or truncate cfg_data to the neuron count
    always_comb begin
        mask_wr = '0;
        for (int b = 0; b < N_NEURONS && b < 8; b++) mask_wr[b] = bus.cfg_data[b];
    end

    // Config registers; new values only reach updates on later edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr_q    <= 8'd200;
            leak_q   <= 3'd1;
            refrac_q <= 4'd2;
            mask_q   <= '1;
        end else if (bus.cfg_we) begin
            case (bus.cfg_addr)
                2'd0: thr_q    <= bus.cfg_data;
                2'd1: leak_q   <= bus.cfg_data[2:0];
                2'd2: refrac_q <= bus.cfg_data[3:0];
                2'd3: mask_q   <= mask_wr;
                default: ;
            endcase
        end
    end

    // FIFO control: a pop frees the slot a full-FIFO push lands in
    always_comb begin
        fifo_full = (count_q == (PTR_W+1)'(FIFO_DEPTH));
        pop       = (count_q != '0) && bus.spk_ready;
        push      = spike && (!fifo_full || pop);
        drop      = spike && fifo_full && !pop;
    end

    // Spike FIFO storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= idx_q;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Sticky overflow; a drop on the clearing edge keeps it set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  overflow_q <= 1'b0;
        else if (drop)                               overflow_q <= 1'b1;
        else if (bus.cfg_we && bus.cfg_addr == 2'd3) overflow_q <= 1'b0;
    end

    // Done pulse and registered membrane readout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q      <= 1'b0;
            state_out_q <= 8'd0;
        end else begin
            done_q      <= last_upd;
            state_out_q <= v_q[bus.state_sel];
        end
    end

    assign bus.done      = done_q;
    assign bus.state_out = state_out_q;
    assign bus.spk_valid = (count_q != '0);
    assign bus.spk_idx   = mem_q[rd_q];
    assign bus.overflow  = overflow_q;
endmodule
